// File: rtl/bus_arbiter_rr_pkg.sv
// rtl/bus_arbiter_rr_pkg.sv - shared control-field positions and FSM encodings for bus_arbiter_rr
package bus_arbiter_rr_pkg;

    localparam int CTRL_WAIT      = 0;
    localparam int CTRL_WE        = 1;
    localparam int CTRL_BURST_LSB = 2;
    localparam int CTRL_BURST_MSB = 4;
    localparam int BURST_W        = CTRL_BURST_MSB - CTRL_BURST_LSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_ADDR    = 3'd2,
        ST_SLAVE   = 3'd3,
        ST_DATA    = 3'd4,
        ST_RELEASE = 3'd5
    } state_e;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rtl/bus_arbiter_rr_picker.sv - combinational round-robin winner search starting after last_i
module rr_picker #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o
);

    logic          found_hi;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // Descending scan leaves the lowest matching index; ports above last_i take precedence.
    always_comb begin
        found_hi = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_idx = IW'(i);
                if (i > int'(last_i)) begin
                    hi_idx   = IW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        idx_o    = found_hi ? hi_idx : lo_idx;
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            onehot_o[i] = req_i[i] && (idx_o == IW'(i));
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin bus arbiter with slave decode, burst sequencing and abort handling
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter int NUM_DEVICES = 8,
    parameter int BUS_WIDTH   = 32,
    parameter int CTRL_WIDTH  = 8,
    parameter int SEL_BITS    = 3,
    parameter int TIMEOUT     = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_DEVICES-1:0]            req,
    output logic [NUM_DEVICES-1:0]            ack,
    input  logic [NUM_DEVICES*CTRL_WIDTH-1:0] ctrl_in,
    output logic [CTRL_WIDTH-1:0]             ctrl_out,
    input  logic [NUM_DEVICES*BUS_WIDTH-1:0]  bus_in,
    output logic [BUS_WIDTH-1:0]              bus_out,
    output logic                              busy,
    output logic [SEL_BITS-1:0]               grant_id,
    output logic                              bus_error
);

    localparam int WCW = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [SEL_BITS-1:0]  master_q, master_d;
    logic [SEL_BITS-1:0]  slave_q, slave_d;
    logic [SEL_BITS-1:0]  last_q, last_d;
    logic [BUS_WIDTH-1:0] phys_q, phys_d;
    logic                 we_q, we_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [BURST_W-1:0]   beat_q, beat_d;
    logic [WCW-1:0]       wait_q, wait_d;

    logic [NUM_DEVICES-1:0] pick_onehot;
    logic [SEL_BITS-1:0]    pick_idx;
    logic [NUM_DEVICES-1:0] m_onehot, s_onehot;
    logic [BUS_WIDTH-1:0]   m_bus, s_bus, src_bus;
    logic [CTRL_WIDTH-1:0]  m_ctrl, s_ctrl;
    logic                   src_wait;
    logic [SEL_BITS-1:0]    addr_sel;
    logic [BUS_WIDTH-1:0]   addr_phys;
    logic                   addr_bad;
    logic                   unused_ctrl_bits;

    rr_picker #(
        .N  (NUM_DEVICES),
        .IW (SEL_BITS)
    ) u_picker (
        .req_i    (req),
        .last_i   (last_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    always_comb begin
        m_bus  = '0;
        s_bus  = '0;
        m_ctrl = '0;
        s_ctrl = '0;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            if (master_q == SEL_BITS'(i)) begin
                m_bus  = bus_in[i*BUS_WIDTH +: BUS_WIDTH];
                m_ctrl = ctrl_in[i*CTRL_WIDTH +: CTRL_WIDTH];
            end
            if (slave_q == SEL_BITS'(i)) begin
                s_bus  = bus_in[i*BUS_WIDTH +: BUS_WIDTH];
                s_ctrl = ctrl_in[i*CTRL_WIDTH +: CTRL_WIDTH];
            end
        end
    end

    assign m_onehot  = {{(NUM_DEVICES-1){1'b0}}, 1'b1} << master_q;
    assign s_onehot  = {{(NUM_DEVICES-1){1'b0}}, 1'b1} << slave_q;
    assign src_bus   = we_q ? m_bus : s_bus;
    assign src_wait  = we_q ? m_ctrl[CTRL_WAIT] : s_ctrl[CTRL_WAIT];
    assign addr_sel  = m_bus[BUS_WIDTH-1 -: SEL_BITS];
    assign addr_phys = {{SEL_BITS{1'b0}}, m_bus[BUS_WIDTH-SEL_BITS-1:0]};
    assign addr_bad  = (int'(addr_sel) >= NUM_DEVICES) || (addr_sel == master_q);
    assign unused_ctrl_bits = ^{m_ctrl, s_ctrl};

    assign busy     = (state_q != ST_IDLE);
    assign grant_id = master_q;

    function automatic logic [CTRL_WIDTH-1:0] pack_ctrl(input logic [BURST_W-1:0] b,
                                                        input logic w, input logic wt);
        logic [CTRL_WIDTH-1:0] c;
        c                                = '0;
        c[CTRL_BURST_MSB:CTRL_BURST_LSB] = b;
        c[CTRL_WE]                       = w;
        c[CTRL_WAIT]                     = wt;
        return c;
    endfunction

    always_comb begin
        state_d   = state_q;
        master_d  = master_q;
        slave_d   = slave_q;
        last_d    = last_q;
        phys_d    = phys_q;
        we_d      = we_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        ack       = '0;
        bus_out   = '0;
        ctrl_out  = '0;
        bus_error = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|pick_onehot) begin
                    master_d = pick_idx;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                ack     = m_onehot;
                state_d = ST_ADDR;
            end
            ST_ADDR: begin
                ack      = m_onehot;
                slave_d  = addr_sel;
                phys_d   = addr_phys;
                we_d     = m_ctrl[CTRL_WE];
                burst_d  = m_ctrl[CTRL_BURST_MSB:CTRL_BURST_LSB];
                bus_out  = addr_phys;
                ctrl_out = pack_ctrl(m_ctrl[CTRL_BURST_MSB:CTRL_BURST_LSB],
                                     m_ctrl[CTRL_WE], m_ctrl[CTRL_WAIT]);
                if (addr_bad) begin
                    bus_error = 1'b1;
                    state_d   = ST_RELEASE;
                end else begin
                    state_d = ST_SLAVE;
                end
            end
            ST_SLAVE: begin
                ack      = s_onehot;
                bus_out  = phys_q;
                ctrl_out = pack_ctrl(burst_q, we_q, 1'b1);
                beat_d   = burst_q;
                wait_d   = '0;
                state_d  = ST_DATA;
            end
            ST_DATA: begin
                ack      = m_onehot | s_onehot;
                bus_out  = src_bus;
                ctrl_out = pack_ctrl(burst_q, we_q, src_wait);
                // A dropped master request outranks both beat completion and timeout.
                if (!(|(req & m_onehot))) begin
                    state_d = ST_RELEASE;
                end else if (!src_wait) begin
                    if (beat_q == '0) begin
                        state_d = ST_RELEASE;
                    end else begin
                        beat_d = beat_q - 1'b1;
                        wait_d = '0;
                    end
                end else if (wait_q == WCW'(TIMEOUT - 1)) begin
                    bus_error = 1'b1;
                    state_d   = ST_RELEASE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                last_d  = master_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            master_q <= '0;
            slave_q  <= '0;
            last_q   <= SEL_BITS'(NUM_DEVICES - 1);
            phys_q   <= '0;
            we_q     <= 1'b0;
            burst_q  <= '0;
            beat_q   <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            master_q <= master_d;
            slave_q  <= slave_d;
            last_q   <= last_d;
            phys_q   <= phys_d;
            we_q     <= we_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - scoreboard bench for bus_arbiter_rr
module tb_bus_arbiter_rr;

    localparam int N  = 8;
    localparam int BW = 32;
    localparam int CW = 8;
    localparam int SB = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, ack;
    logic [N*CW-1:0] ctrl_in;
    logic [CW-1:0]   ctrl_out;
    logic [N*BW-1:0] bus_in;
    logic [BW-1:0]   bus_out;
    logic            busy, bus_error;
    logic [SB-1:0]   grant_id;

    logic [5:0]      req6, ack6;
    logic [6*CW-1:0] ctrl_in6;
    logic [CW-1:0]   ctrl_out6;
    logic [6*BW-1:0] bus_in6;
    logic [BW-1:0]   bus_out6;
    logic            busy6, bus_error6;
    logic [SB-1:0]   grant_id6;

    always #5 clk = ~clk;

    bus_arbiter_rr #(.NUM_DEVICES(N)) dut (
        .clk(clk), .reset(reset), .req(req), .ack(ack),
        .ctrl_in(ctrl_in), .ctrl_out(ctrl_out), .bus_in(bus_in), .bus_out(bus_out),
        .busy(busy), .grant_id(grant_id), .bus_error(bus_error)
    );

    bus_arbiter_rr #(.NUM_DEVICES(6)) dut6 (
        .clk(clk), .reset(reset), .req(req6), .ack(ack6),
        .ctrl_in(ctrl_in6), .ctrl_out(ctrl_out6), .bus_in(bus_in6), .bus_out(bus_out6),
        .busy(busy6), .grant_id(grant_id6), .bus_error(bus_error6)
    );

    typedef struct packed {
        logic [7:0]  ack;
        logic [31:0] bus;
        logic [7:0]  ctrl;
        logic        busy;
        logic        err;
        logic [2:0]  gid;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_x;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc_no = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_x = sb_q.pop_front();
            check_eq($sformatf("ack@%0d", cyc_no),      32'(ack),       32'(mon_x.ack));
            check_eq($sformatf("bus_out@%0d", cyc_no),  bus_out,        mon_x.bus);
            check_eq($sformatf("ctrl_out@%0d", cyc_no), 32'(ctrl_out),  32'(mon_x.ctrl));
            check_eq($sformatf("busy@%0d", cyc_no),     32'(busy),      32'(mon_x.busy));
            check_eq($sformatf("bus_error@%0d", cyc_no),32'(bus_error), 32'(mon_x.err));
            check_eq($sformatf("grant_id@%0d", cyc_no), 32'(grant_id),  32'(mon_x.gid));
        end
        cyc_no++;
    end

    function automatic logic [7:0] oh(input int p);
        return 8'd1 << p;
    endfunction

    task automatic set_port(input int p, input logic [31:0] b, input logic [7:0] c);
        bus_in[p*BW +: BW]  = b;
        ctrl_in[p*CW +: CW] = c;
    endtask

    task automatic cyc(input logic [7:0] a, input logic [31:0] b, input logic [7:0] c,
                       input logic bsy, input logic e, input logic [2:0] g);
        exp_t x;
        x.ack = a; x.bus = b; x.ctrl = c; x.busy = bsy; x.err = e; x.gid = g;
        sb_q.push_back(x);
        @(posedge clk); #1;
    endtask

    // IDLE (arbitrating), GRANT, ADDR, SLAVE for a legal transfer m -> s.
    task automatic xfer_head(input int m, input int s, input logic [31:0] addr,
                             input logic [7:0] c, input logic [2:0] gprev);
        logic [31:0] phys;
        phys = {3'b000, addr[28:0]};
        cyc(8'h00, 32'h0, 8'h00, 1'b0, 1'b0, gprev);
        cyc(oh(m), 32'h0, 8'h00, 1'b1, 1'b0, 3'(m));
        cyc(oh(m), phys, {3'b000, c[4:0]}, 1'b1, 1'b0, 3'(m));
        cyc(oh(s), phys, {3'b000, c[4:2], c[1], 1'b1}, 1'b1, 1'b0, 3'(m));
    endtask

    // Single-beat write with no wait: master drives its address word as data.
    task automatic xfer_single(input int m, input int s, input logic [31:0] addr,
                               input logic [7:0] c, input logic [2:0] gprev);
        xfer_head(m, s, addr, c, gprev);
        cyc(oh(m) | oh(s), addr, {3'b000, c[4:1], 1'b0}, 1'b1, 1'b0, 3'(m));
        cyc(8'h00, 32'h0, 8'h00, 1'b1, 1'b0, 3'(m));
    endtask

    task automatic step6(input string tag, input logic [5:0] a, input logic bsy, input logic e);
        @(negedge clk);
        check_eq({tag, ".ack6"}, 32'(ack6), 32'(a));
        check_eq({tag, ".busy6"}, 32'(busy6), 32'(bsy));
        check_eq({tag, ".err6"}, 32'(bus_error6), 32'(e));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = '0; ctrl_in = '0; bus_in = '0;
        req6 = '0; ctrl_in6 = '0; bus_in6 = '0;
        @(posedge clk); #1;
        cyc(8'h00, 32'h0, 8'h00, 1'b0, 1'b0, 3'd0);
        reset = 1'b0;

        // basic write: master 0 -> slave 1
        set_port(0, 32'h2000_0040, 8'h02);
        set_port(1, 32'h1111_1111, 8'h00);
        req = 8'h01;
        xfer_single(0, 1, 32'h2000_0040, 8'h02, 3'd0);
        req = 8'h00;
        cyc(8'h00, 32'h0, 8'h00, 1'b0, 1'b0, 3'd0);

        // round robin between ports 0 and 2, then 7 after 2
        set_port(2, 32'h6000_0080, 8'h02);
        req = 8'h05;
        xfer_single(2, 3, 32'h6000_0080, 8'h02, 3'd0);
        xfer_single(0, 1, 32'h2000_0040, 8'h02, 3'd2);
        xfer_single(2, 3, 32'h6000_0080, 8'h02, 3'd0);
        set_port(7, 32'h0000_0100, 8'h02);
        req = 8'h84;
        xfer_single(7, 0, 32'h0000_0100, 8'h02, 3'd2);
        xfer_single(2, 3, 32'h6000_0080, 8'h02, 3'd7);

        // read burst of 4 from slave 3 with toggling WAIT
        set_port(1, 32'h6000_0200, 8'h0C);
        req = 8'h02;
        xfer_head(1, 3, 32'h6000_0200, 8'h0C, 3'd2);
        for (int i = 0; i < 8; i++) begin
            logic w;
            w = (i % 2 == 0);
            set_port(3, 32'hD000_0000 + 32'(i), {7'b0, w});
            cyc(8'h0A, 32'hD000_0000 + 32'(i), {7'b0000110, w}, 1'b1, 1'b0, 3'd1);
        end
        cyc(8'h00, 32'h0, 8'h00, 1'b1, 1'b0, 3'd1);

        // timeout: slave 5 holds WAIT, then port 0 is granted
        set_port(4, 32'hA000_0010, 8'h00);
        set_port(5, 32'h5555_0000, 8'h01);
        req = 8'h11;
        xfer_head(4, 5, 32'hA000_0010, 8'h00, 3'd1);
        for (int i = 0; i < 16; i++) begin
            cyc(8'h30, 32'h5555_0000, 8'h01, 1'b1, (i == 15), 3'd4);
        end
        cyc(8'h00, 32'h0, 8'h00, 1'b1, 1'b0, 3'd4);
        xfer_single(0, 1, 32'h2000_0040, 8'h02, 3'd4);

        // master 2 targets itself; reserved ctrl bits must be masked
        set_port(2, 32'h4000_0000, 8'hE6);
        req = 8'h04;
        cyc(8'h00, 32'h0, 8'h00, 1'b0, 1'b0, 3'd0);
        cyc(8'h04, 32'h0, 8'h00, 1'b1, 1'b0, 3'd2);
        cyc(8'h04, 32'h0, 8'h06, 1'b1, 1'b1, 3'd2);
        req = 8'h00;
        cyc(8'h00, 32'h0, 8'h00, 1'b1, 1'b0, 3'd2);
        cyc(8'h00, 32'h0, 8'h00, 1'b0, 1'b0, 3'd2);

        // six-port instance: target 7 does not exist
        bus_in6[0 +: BW] = 32'hE000_0000;
        ctrl_in6[0 +: CW] = 8'h02;
        req6 = 6'h01;
        step6("ill6.idle", 6'h00, 1'b0, 1'b0);
        step6("ill6.grant", 6'h01, 1'b1, 1'b0);
        step6("ill6.addr", 6'h01, 1'b1, 1'b1);
        req6 = 6'h00;
        step6("ill6.release", 6'h00, 1'b1, 1'b0);
        step6("ill6.idle2", 6'h00, 1'b0, 1'b0);

        // master 3 drops req mid-burst
        set_port(3, 32'hC000_0000, 8'h0E);
        set_port(6, 32'h6666_6666, 8'h00);
        req = 8'h08;
        xfer_head(3, 6, 32'hC000_0000, 8'h0E, 3'd2);
        cyc(8'h48, 32'hC000_0000, 8'h0E, 1'b1, 1'b0, 3'd3);
        cyc(8'h48, 32'hC000_0000, 8'h0E, 1'b1, 1'b0, 3'd3);
        req = 8'h00;
        cyc(8'h48, 32'hC000_0000, 8'h0E, 1'b1, 1'b0, 3'd3);
        cyc(8'h00, 32'h0, 8'h00, 1'b1, 1'b0, 3'd3);
        cyc(8'h00, 32'h0, 8'h00, 1'b0, 1'b0, 3'd3);

        // reset during DATA, then port 0 must beat port 5
        set_port(5, 32'h0000_0300, 8'h0A);
        req = 8'h20;
        xfer_head(5, 0, 32'h0000_0300, 8'h0A, 3'd3);
        cyc(8'h21, 32'h0000_0300, 8'h0A, 1'b1, 1'b0, 3'd5);
        reset = 1'b1;
        cyc(8'h21, 32'h0000_0300, 8'h0A, 1'b1, 1'b0, 3'd5);
        reset = 1'b0;
        req = 8'h21;
        xfer_single(0, 1, 32'h2000_0040, 8'h02, 3'd0);
        req = 8'h00;
        cyc(8'h00, 32'h0, 8'h00, 1'b0, 1'b0, 3'd0);

        check_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
